// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared types and helpers for the JK sequence controller.
//   op_e    : command opcodes (cmd_op encoding); codes 6/7 decode to OP_NOP
//   state_e : controller FSM states
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_LOAD   = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_UP     = 3'd4,
    OP_DOWN   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Map the raw 3-bit opcode onto op_e; unused codes behave as NOP.
  function automatic op_e decode_op(input logic [2:0] code);
    case (code)
      3'd1:    return OP_CLEAR;
      3'd2:    return OP_LOAD;
      3'd3:    return OP_TOGGLE;
      3'd4:    return OP_UP;
      3'd5:    return OP_DOWN;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic logic is_count_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_seq_ctrl_cell.sv
// jk_cell: single JK flip-flop with synchronous active-high reset to 0.
//   clk, reset : clock / sync reset
//   j, k       : 00 hold, 01 clear, 10 set, 11 toggle
//   q, qnot    : state and its complement
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qnot
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qnot = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command-driven controller for a bank of WIDTH JK flip-flops.
//   clk, reset : clock / synchronous active-high reset
//   cmd_valid  : command present; accepted when cmd_ready is high
//   cmd_ready  : high only while IDLE
//   cmd_op     : 0 NOP, 1 CLEAR, 2 LOAD, 3 TOGGLE, 4 UP, 5 DOWN (6/7 NOP)
//   cmd_data   : LOAD value / TOGGLE mask
//   cmd_steps  : step count for UP/DOWN
//   q          : JK bank outputs (only ever changed through the JK cells)
//   busy       : controller not IDLE
//   done       : one-cycle pulse when a command completes
//   wrap       : one-cycle pulse after a count edge that wrapped q
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] qnot;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_cond;
  op_e              op_in;

  assign op_in = decode_op(cmd_op);

  // A count edge wraps when UP leaves all-ones or DOWN leaves zero.
  assign wrap_cond = ((op_r == OP_UP)   && (&q)) ||
                     ((op_r == OP_DOWN) && (&qnot));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_r      <= OP_NOP;
      data_r    <= '0;
      remaining <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r      <= op_in;
            data_r    <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (is_count_op(op_in)) begin
              remaining <= cmd_steps;
              if (cmd_steps == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_EXEC;
              end
            end else begin
              // Single-cycle ops reuse the counter with a count of one.
              remaining <= CNT_W'(1);
              state     <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          remaining <= remaining - CNT_W'(1);
          wrap      <= wrap_cond;
          if (remaining == CNT_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Per-bit j/k; counting toggles bit i when every lower bit is 1 (UP)
  // or every lower bit is 0 (DOWN), computed as a running prefix AND.
  always_comb begin
    logic carry_up;
    logic carry_dn;
    j        = '0;
    k        = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    if (state == ST_EXEC) begin
      case (op_r)
        OP_CLEAR: begin
          j = '0;
          k = '1;
        end
        OP_LOAD: begin
          j = data_r;
          k = ~data_r;
        end
        OP_TOGGLE: begin
          j = data_r;
          k = data_r;
        end
        OP_UP: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            j[i]     = carry_up;
            k[i]     = carry_up;
            carry_up = carry_up & q[i];
          end
        end
        OP_DOWN: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            j[i]     = carry_dn;
            k[i]     = carry_dn;
            carry_dn = carry_dn & qnot[i];
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g]),
      .qnot  (qnot[g])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
module tb_jk_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MODW  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_steps;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  jk_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int q;
    int wraps;
    int latency;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_q  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on the value, not on bits.
  task automatic issue(input int op, input int data, input int steps);
    exp_t e;
    int   n;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    n       = steps;
    e.op    = op;
    e.wraps = 0;
    e.latency = 1;
    case (op)
      1: model_q = 0;
      2: model_q = data;
      3: model_q = model_q ^ data;
      4: begin
        e.wraps   = (model_q + n) / MODW;
        model_q   = (model_q + n) % MODW;
        e.latency = n;
      end
      5: begin
        e.wraps   = (n >= model_q + 1) ? ((n - model_q - 1) / MODW + 1) : 0;
        model_q   = ((model_q - (n % MODW)) + MODW) % MODW;
        e.latency = n;
      end
      default: ;
    endcase
    e.q = model_q;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = WIDTH'(data);
    cmd_steps = CNT_W'(steps);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: tracks accepts, counts wraps, pops the scoreboard on done.
  int cyc = 0;
  int acc_cyc = 0;
  int wrap_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset && cmd_valid && cmd_ready) begin
        acc_cyc  = cyc;
        wrap_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && wrap) begin
        wrap_cnt++;
        if (sb.size() == 0) chk("wrap_unexpected", 1, 0);
        else if (sb[0].op == 4) chk("wrap_up_q", int'(q), 0);
        else if (sb[0].op == 5) chk("wrap_down_q", int'(q), MODW - 1);
        else chk("wrap_op", sb[0].op, 4);
      end
      if (!reset && done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_q", int'(q), e.q);
          chk("done_latency", cyc - acc_cyc, e.latency);
          chk("done_wraps", wrap_cnt, e.wraps);
        end
      end
    end
  end

  initial begin
    int op;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_steps = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_ready", int'(cmd_ready), 1);

    // Directed sequences
    issue(2, 'hA, 0);
    issue(3, 'h5, 0);
    issue(1, 0, 0);
    issue(2, 'hE, 0);
    issue(4, 0, 3);
    issue(1, 0, 0);
    issue(5, 0, 2);
    issue(4, 0, 0);
    issue(6, 'h3, 5);
    issue(7, 'hF, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      issue(op, int'($urandom_range(0, MODW - 1)), int'($urandom_range(0, 40)));
    end

    // Reset mid-command, with a command pulse ignored while busy
    issue(1, 0, 0);
    issue(4, 0, 10);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_data  = 4'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_ignore_q", int'(q), 2);
    @(negedge clk);
    chk("pre_reset_q", int'(q), 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    model_q = 0;
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_wrap", int'(wrap), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_q", int'(q), 0);
    chk("post_rst_ready", int'(cmd_ready), 1);

    issue(5, 0, 17);
    issue(4, 0, 33);

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
